// File: rtl/mips_mc_controller.sv
// Multicycle MIPS control unit: Moore FSM sequencing fetch/decode/execute for
// lw, sw, R-type (add/sub/and/or/slt), beq, addi and j, with overflow and illegal-instruction exceptions.
module mips_mc_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       overflow,
    output logic [2:0] alucontrol,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic       iord,
    output logic       irwrite,
    output logic       memwrite,
    output logic       regwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       pcen,
    output logic       ovf_exc,
    output logic       illegal_exc,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11,
        S_ILLEGAL = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    // Kept as plain logic so out-of-range codes 13-15 are representable.
    logic [3:0] r_state;
    logic       r_ovf_q;
    logic       r_is_trap;

    logic       w_functLegal;
    logic [2:0] w_rtypeAluc;

    always_comb begin
        w_functLegal = 1'b1;
        w_rtypeAluc  = 3'b010;
        case (funct)
            FN_ADD:  w_rtypeAluc = 3'b010;
            FN_SUB:  w_rtypeAluc = 3'b110;
            FN_AND:  w_rtypeAluc = 3'b000;
            FN_OR:   w_rtypeAluc = 3'b001;
            FN_SLT:  w_rtypeAluc = 3'b111;
            default: w_functLegal = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_FETCH;
            r_ovf_q   <= 1'b0;
            r_is_trap <= 1'b0;
        end else begin
            case (r_state)
                S_FETCH:  r_state <= S_DECODE;
                S_DECODE: begin
                    if (op == OP_LW || op == OP_SW)              r_state <= S_MEMADR;
                    else if (op == OP_RTYPE && w_functLegal)     r_state <= S_EXECUTE;
                    else if (op == OP_BEQ)                       r_state <= S_BRANCH;
                    else if (op == OP_ADDI)                      r_state <= S_ADDIEX;
                    else if (op == OP_J)                         r_state <= S_JUMP;
                    else                                         r_state <= S_ILLEGAL;
                end
                S_MEMADR: r_state <= (op == OP_LW) ? S_MEMRD : S_MEMWR;
                S_MEMRD:  r_state <= S_MEMWB;
                // Only add/sub trap on overflow; and/or/slt results are always written.
                S_EXECUTE: begin
                    r_state   <= S_ALUWB;
                    r_ovf_q   <= overflow;
                    r_is_trap <= (funct == FN_ADD) || (funct == FN_SUB);
                end
                S_ADDIEX: begin
                    r_state   <= S_ADDIWB;
                    r_ovf_q   <= overflow;
                    r_is_trap <= 1'b1;
                end
                default:  r_state <= S_FETCH;
            endcase
        end
    end

    always_comb begin
        alucontrol  = 3'b000;
        alusrca     = 1'b0;
        alusrcb     = 2'b00;
        pcsrc       = 2'b00;
        iord        = 1'b0;
        irwrite     = 1'b0;
        memwrite    = 1'b0;
        regwrite    = 1'b0;
        regdst      = 1'b0;
        memtoreg    = 1'b0;
        pcen        = 1'b0;
        ovf_exc     = 1'b0;
        illegal_exc = 1'b0;
        case (r_state)
            S_FETCH: begin
                irwrite    = 1'b1;
                pcen       = 1'b1;
                alusrcb    = 2'b01;
                alucontrol = 3'b010;
            end
            S_DECODE: begin
                alusrcb    = 2'b11;
                alucontrol = 3'b010;
            end
            S_MEMADR, S_ADDIEX: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                alucontrol = 3'b010;
            end
            S_MEMRD:  iord = 1'b1;
            S_MEMWB: begin
                regwrite = 1'b1;
                memtoreg = 1'b1;
            end
            S_MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
            end
            S_EXECUTE: begin
                alusrca    = 1'b1;
                alucontrol = w_rtypeAluc;
            end
            S_ALUWB: begin
                regdst   = 1'b1;
                regwrite = !(r_ovf_q && r_is_trap);
                ovf_exc  = r_ovf_q && r_is_trap;
            end
            S_ADDIWB: begin
                regwrite = !r_ovf_q;
                ovf_exc  = r_ovf_q;
            end
            S_BRANCH: begin
                alusrca    = 1'b1;
                alucontrol = 3'b110;
                pcsrc      = 2'b01;
                pcen       = zero;
            end
            S_JUMP: begin
                pcsrc = 2'b10;
                pcen  = 1'b1;
            end
            S_ILLEGAL: illegal_exc = 1'b1;
            default: ;
        endcase
        // Reset suppresses every architectural write even mid-instruction.
        if (reset) begin
            pcen        = 1'b0;
            irwrite     = 1'b0;
            regwrite    = 1'b0;
            memwrite    = 1'b0;
            ovf_exc     = 1'b0;
            illegal_exc = 1'b0;
        end
    end

    assign state = r_state;

endmodule
